// File: rtl/aes_pkg.sv
// Shared definitions for the AES round datapath: per-beat mode encoding,
// Rijndael row-shift offsets and the byte-position helper for the column-major state.
package aes_pkg;

    localparam logic [1:0] MODE_FWD = 2'b00;
    localparam logic [1:0] MODE_INV = 2'b01;
    localparam logic [1:0] MODE_BYP = 2'b10;

    // Rijndael offsets: 0,1,2,3 for 4/6 columns, 0,1,3,4 for 8 columns.
    function automatic int row_shift(input int nb, input int r);
        if (r == 0) return 0;
        if (nb == 8 && r >= 2) return r + 1;
        return r;
    endfunction

    // Byte (r,c) of the state lives at bit offset (4c+r)*8.
    function automatic int byte_offset(input int r, input int c);
        return (4 * c + r) * 8;
    endfunction

endpackage

// File: rtl/rijndael_row_permute.sv
// Combinational Rijndael row rotation: forward ShiftRows, inverse, or pass-through.
// Pure byte routing, no arithmetic.
module rijndael_row_permute
    import aes_pkg::*;
#(
    parameter int NB = 4
) (
    input  logic [1:0]      mode,
    input  logic [32*NB-1:0] data_in,
    output logic [32*NB-1:0] data_out
);

    if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
        $error("rijndael_row_permute: NB must be 4, 6 or 8");
    end

    logic [32*NB-1:0] fwd;
    logic [32*NB-1:0] inv;

    for (genvar c = 0; c < NB; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign fwd[byte_offset(r, c) +: 8] =
                data_in[byte_offset(r, (c + row_shift(NB, r)) % NB) +: 8];
            assign inv[byte_offset(r, c) +: 8] =
                data_in[byte_offset(r, (c - row_shift(NB, r) + NB) % NB) +: 8];
        end
    end

    // NOTE: a default assignment ahead of the case keeps every path driven, so no latch is inferred.
    always_comb begin
        data_out = data_in;
        case (mode)
            MODE_FWD: data_out = fwd;
            MODE_INV: data_out = inv;
            MODE_BYP: data_out = data_in;
            default:  data_out = data_in;
        endcase
    end

endmodule

// File: rtl/shift_rows_stream.sv
// Stream-handshaked row-shift stage: permutes on accept, then holds beats in an
// output register plus a skid register so in_ready never depends on out_ready.
module shift_rows_stream
    import aes_pkg::*;
#(
    parameter int NB    = 4,
    parameter int TAG_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_mode,
    input  logic [TAG_W-1:0]  in_tag,
    input  logic [32*NB-1:0]  in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [TAG_W-1:0]  out_tag,
    output logic [32*NB-1:0]  out_data
);

    localparam int W = 32 * NB;

    logic [W-1:0]     perm_data;
    logic             accept;
    logic             drain;
    logic             in_ready_q;
    logic             o_valid_q, o_valid_d;
    logic             s_valid_q, s_valid_d;
    logic [W-1:0]     o_data_q, o_data_d;
    logic [W-1:0]     s_data_q, s_data_d;
    logic [TAG_W-1:0] o_tag_q, o_tag_d;
    logic [TAG_W-1:0] s_tag_q, s_tag_d;

    rijndael_row_permute #(.NB(NB)) u_permute (
        .mode     (in_mode),
        .data_in  (in_data),
        .data_out (perm_data)
    );

    assign accept = in_valid && in_ready_q;
    assign drain  = o_valid_q && out_ready;

    always_comb begin
        o_valid_d = o_valid_q;
        o_data_d  = o_data_q;
        o_tag_d   = o_tag_q;
        s_valid_d = s_valid_q;
        s_data_d  = s_data_q;
        s_tag_d   = s_tag_q;

        if (drain) begin
            if (s_valid_q) begin
                // in_ready is low whenever S is full, so no accept can coincide here.
                o_data_d  = s_data_q;
                o_tag_d   = s_tag_q;
                s_valid_d = 1'b0;
            end else if (accept) begin
                o_data_d = perm_data;
                o_tag_d  = in_tag;
            end else begin
                o_valid_d = 1'b0;
            end
        end else if (accept) begin
            if (!o_valid_q) begin
                o_valid_d = 1'b1;
                o_data_d  = perm_data;
                o_tag_d   = in_tag;
            end else begin
                s_valid_d = 1'b1;
                s_data_d  = perm_data;
                s_tag_d   = in_tag;
            end
        end
    end

    // NOTE: data registers are reset too, because out_data/out_tag must read zero after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            in_ready_q <= 1'b0;
            o_valid_q  <= 1'b0;
            s_valid_q  <= 1'b0;
            o_data_q   <= '0;
            s_data_q   <= '0;
            o_tag_q    <= '0;
            s_tag_q    <= '0;
        end else begin
            in_ready_q <= !s_valid_d;
            o_valid_q  <= o_valid_d;
            s_valid_q  <= s_valid_d;
            o_data_q   <= o_data_d;
            s_data_q   <= s_data_d;
            o_tag_q    <= o_tag_d;
            s_tag_q    <= s_tag_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = o_valid_q;
    assign out_data  = o_data_q;
    assign out_tag   = o_tag_q;

endmodule

// File: tb/tb_shift_rows_stream.sv
// Bench for shift_rows_stream: NB=4 and NB=8 instances checked against a
// row/column array model of Rijndael ShiftRows and a FIFO scoreboard.
module tb_shift_rows_stream;

    localparam logic [127:0] VEC_IN  = 128'h3052411ee55db4b8f198bfe0ae1127d4;
    localparam logic [127:0] VEC_FWD = 128'he598271ef11141b8ae52b4e0305dbfd4;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic         in_valid4, in_ready4, out_valid4, out_ready4;
    logic [1:0]   in_mode4;
    logic [3:0]   in_tag4, out_tag4;
    logic [127:0] in_data4, out_data4;

    logic         in_valid8, in_ready8, out_valid8, out_ready8;
    logic [1:0]   in_mode8;
    logic [3:0]   in_tag8, out_tag8;
    logic [255:0] in_data8, out_data8;

    shift_rows_stream #(.NB(4), .TAG_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid4), .in_ready(in_ready4), .in_mode(in_mode4),
        .in_tag(in_tag4), .in_data(in_data4),
        .out_valid(out_valid4), .out_ready(out_ready4),
        .out_tag(out_tag4), .out_data(out_data4)
    );

    shift_rows_stream #(.NB(8), .TAG_W(4)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid8), .in_ready(in_ready8), .in_mode(in_mode8),
        .in_tag(in_tag8), .in_data(in_data8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .out_tag(out_tag8), .out_data(out_data8)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int out_count = 0;
    logic [127:0] exp_q[$];
    logic [3:0]   exp_tag_q[$];

    // Reference: unpack into state[row][col], rotate each row by its offset, repack.
    function automatic logic [255:0] ref_perm(input int nb, input logic [1:0] mode,
                                              input logic [255:0] d);
        logic [7:0]   st[4][8];
        int           sh[4];
        int           src;
        logic [255:0] res;
        sh[0] = 0; sh[1] = 1;
        sh[2] = (nb == 8) ? 3 : 2;
        sh[3] = (nb == 8) ? 4 : 3;
        for (int c = 0; c < nb; c++)
            for (int r = 0; r < 4; r++)
                st[r][c] = d[(4*c+r)*8 +: 8];
        res = d;
        if (mode == 2'b00 || mode == 2'b01) begin
            res = '0;
            for (int c = 0; c < nb; c++)
                for (int r = 0; r < 4; r++) begin
                    src = (mode == 2'b00) ? (c + sh[r]) % nb : (c - sh[r] + nb) % nb;
                    res[(4*c+r)*8 +: 8] = st[r][src];
                end
        end
        return res;
    endfunction

    function automatic logic [127:0] ref4(input logic [1:0] mode, input logic [127:0] d);
        logic [255:0] t;
        t = ref_perm(4, mode, {128'b0, d});
        return t[127:0];
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One NB=4 clock: log transfers at the falling edge, then step past the rising edge.
    task automatic cycle4();
        logic [127:0] e;
        logic [3:0]   t;
        @(negedge clk);
        if (in_valid4 && in_ready4) begin
            exp_q.push_back(ref4(in_mode4, in_data4));
            exp_tag_q.push_back(in_tag4);
        end
        if (out_valid4 && out_ready4) begin
            n_tests++;
            out_count++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_spurious: got data=%h tag=%h, want no beat", out_data4, out_tag4);
            end else begin
                e = exp_q.pop_front();
                t = exp_tag_q.pop_front();
                if (out_data4 !== e || out_tag4 !== t) begin
                    n_fail++;
                    $display("FAIL sb_order: got data=%h tag=%h, want data=%h tag=%h",
                             out_data4, out_tag4, e, t);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid4 = 0; in_mode4 = 0; in_tag4 = 0; in_data4 = '0; out_ready4 = 0;
        in_valid8 = 0; in_mode8 = 0; in_tag8 = 0; in_data8 = '0; out_ready8 = 0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (in_ready4 !== 1'b0 || in_ready8 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b/%b, want 0/0", in_ready4, in_ready8);
        end
        n_tests++;
        if (out_valid4 !== 1'b0 || out_data4 !== '0 || out_tag4 !== '0 ||
            out_valid8 !== 1'b0 || out_data8 !== '0 || out_tag8 !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b d=%h t=%h, want all zero",
                     out_valid4, out_data4, out_tag4);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_tests++;
        if (in_ready4 !== 1'b1 || in_ready8 !== 1'b1 || out_valid4 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: got rdy=%b/%b v=%b, want rdy=1/1 v=0",
                     in_ready4, in_ready8, out_valid4);
        end
    endtask

    task automatic test_forward_nb4();
        out_ready4 = 1; in_valid4 = 1; in_mode4 = 2'b00; in_tag4 = 4'd3; in_data4 = VEC_IN;
        cycle4();
        in_valid4 = 0;
        n_tests++;
        if (out_valid4 !== 1'b1 || out_data4 !== VEC_FWD || out_tag4 !== 4'd3) begin
            n_fail++;
            $display("FAIL fwd_nb4: got v=%b d=%h t=%h, want v=1 d=%h t=3",
                     out_valid4, out_data4, out_tag4, VEC_FWD);
        end
        cycle4();
    endtask

    task automatic test_inverse_bypass_nb4();
        logic [127:0] d;
        out_ready4 = 1; in_valid4 = 1; in_mode4 = 2'b01; in_tag4 = 4'd5; in_data4 = VEC_FWD;
        cycle4();
        in_valid4 = 0;
        n_tests++;
        if (out_valid4 !== 1'b1 || out_data4 !== VEC_IN || out_tag4 !== 4'd5) begin
            n_fail++;
            $display("FAIL inv_nb4: got v=%b d=%h t=%h, want v=1 d=%h t=5",
                     out_valid4, out_data4, out_tag4, VEC_IN);
        end
        cycle4();
        for (int m = 2; m < 4; m++) begin
            d = rand128();
            in_valid4 = 1; in_mode4 = 2'(m); in_tag4 = 4'(m + 8); in_data4 = d;
            cycle4();
            in_valid4 = 0;
            n_tests++;
            if (out_valid4 !== 1'b1 || out_data4 !== d) begin
                n_fail++;
                $display("FAIL bypass_mode%0d: got v=%b d=%h, want v=1 d=%h",
                         m, out_valid4, out_data4, d);
            end
            cycle4();
        end
    endtask

    task automatic test_nb8();
        logic [255:0] ident;
        logic [255:0] e;
        for (int k = 0; k < 32; k++) ident[k*8 +: 8] = 8'(k);
        out_ready8 = 1; in_valid8 = 1; in_mode8 = 2'b00; in_tag8 = 4'd7; in_data8 = ident;
        @(posedge clk);
        #1;
        e = ref_perm(8, 2'b00, ident);
        n_tests++;
        if (out_valid8 !== 1'b1 || out_data8[31:0] !== 32'h130e0500 || out_tag8 !== 4'd7) begin
            n_fail++;
            $display("FAIL fwd_nb8_row0: got v=%b bytes=%h t=%h, want v=1 bytes=130e0500 t=7",
                     out_valid8, out_data8[31:0], out_tag8);
        end
        n_tests++;
        if (out_data8 !== e) begin
            n_fail++;
            $display("FAIL fwd_nb8_full: got %h, want %h", out_data8, e);
        end
        in_mode8 = 2'b01; in_tag8 = 4'd8; in_data8 = e;
        @(posedge clk);
        #1;
        n_tests++;
        if (out_valid8 !== 1'b1 || out_data8 !== ident || out_tag8 !== 4'd8) begin
            n_fail++;
            $display("FAIL inv_nb8_identity: got v=%b d=%h, want v=1 d=%h", out_valid8, out_data8, ident);
        end
        for (int i = 0; i < 6; i++) begin
            in_mode8 = 2'($urandom_range(0, 3));
            in_tag8  = 4'(i);
            in_data8 = {rand128(), rand128()};
            e = ref_perm(8, in_mode8, in_data8);
            @(posedge clk);
            #1;
            n_tests++;
            if (out_valid8 !== 1'b1 || out_data8 !== e || out_tag8 !== 4'(i) || in_ready8 !== 1'b1) begin
                n_fail++;
                $display("FAIL rand_nb8_%0d: got v=%b r=%b d=%h, want v=1 r=1 d=%h",
                         i, out_valid8, in_ready8, out_data8, e);
            end
        end
        in_valid8 = 0;
    endtask

    task automatic test_backpressure();
        int c0;
        c0 = out_count;
        out_ready4 = 0;
        in_valid4 = 1; in_mode4 = 2'b00; in_tag4 = 4'h1; in_data4 = rand128();
        cycle4();
        in_mode4 = 2'b01; in_tag4 = 4'h2; in_data4 = rand128();
        n_tests++;
        if (in_ready4 !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_accept_b: got in_ready=%b, want 1", in_ready4);
        end
        cycle4();
        in_mode4 = 2'b10; in_tag4 = 4'h3; in_data4 = rand128();
        repeat (2) begin
            n_tests++;
            if (in_ready4 !== 1'b0 || out_valid4 !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_full: got rdy=%b v=%b, want rdy=0 v=1", in_ready4, out_valid4);
            end
            cycle4();
        end
        out_ready4 = 1;
        cycle4();
        n_tests++;
        if (in_ready4 !== 1'b1 || out_valid4 !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_reassert: got rdy=%b v=%b, want rdy=1 v=1", in_ready4, out_valid4);
        end
        cycle4();
        in_valid4 = 0;
        n_tests++;
        if (out_valid4 !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_gap: got out_valid=%b, want 1", out_valid4);
        end
        cycle4();
        n_tests++;
        if (out_count - c0 !== 3 || exp_q.size() != 0 || out_valid4 !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_count: got %0d beats pending=%0d v=%b, want 3 beats pending=0 v=0",
                     out_count - c0, exp_q.size(), out_valid4);
        end
    endtask

    task automatic test_streaming();
        int   sent;
        int   budget;
        int   c0;
        logic acc;
        sent = 0; budget = 0; c0 = out_count;
        in_valid4 = 1; in_mode4 = 2'($urandom_range(0, 3)); in_tag4 = 4'(0); in_data4 = rand128();
        while (sent < 20 && budget < 400) begin
            out_ready4 = 1'($urandom_range(0, 1));
            acc = in_ready4;
            cycle4();
            budget++;
            if (acc) begin
                sent++;
                in_mode4 = 2'($urandom_range(0, 3));
                in_tag4  = 4'(sent);
                in_data4 = rand128();
            end
        end
        in_valid4 = 0;
        out_ready4 = 1;
        while (exp_q.size() != 0 && budget < 450) begin
            cycle4();
            budget++;
        end
        n_tests++;
        if (sent != 20 || out_count - c0 !== 20 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL stream_count: got sent=%0d out=%0d pending=%0d, want 20/20/0",
                     sent, out_count - c0, exp_q.size());
        end
    endtask

    task automatic test_reset_midstream();
        logic [127:0] d;
        out_ready4 = 0;
        in_valid4 = 1; in_mode4 = 2'b00; in_tag4 = 4'hA; in_data4 = rand128();
        cycle4();
        in_tag4 = 4'hB; in_data4 = rand128();
        cycle4();
        in_valid4 = 0;
        n_tests++;
        if (in_ready4 !== 1'b0 || out_valid4 !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_full: got rdy=%b v=%b, want rdy=0 v=1", in_ready4, out_valid4);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (out_valid4 !== 1'b0 || out_data4 !== '0 || out_tag4 !== '0 || in_ready4 !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_async_reset: got v=%b d=%h t=%h rdy=%b, want all zero",
                     out_valid4, out_data4, out_tag4, in_ready4);
        end
        exp_q.delete();
        exp_tag_q.delete();
        @(posedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        out_ready4 = 1;
        @(posedge clk);
        #1;
        n_tests++;
        if (in_ready4 !== 1'b1 || out_valid4 !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_release: got rdy=%b v=%b, want rdy=1 v=0", in_ready4, out_valid4);
        end
        cycle4();
        n_tests++;
        if (out_valid4 !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_stale: got out_valid=%b, want 0", out_valid4);
        end
        d = rand128();
        in_valid4 = 1; in_mode4 = 2'b01; in_tag4 = 4'hC; in_data4 = d;
        cycle4();
        in_valid4 = 0;
        n_tests++;
        if (out_valid4 !== 1'b1 || out_data4 !== ref4(2'b01, d) || out_tag4 !== 4'hC) begin
            n_fail++;
            $display("FAIL mid_latency: got v=%b d=%h t=%h, want v=1 d=%h t=c",
                     out_valid4, out_data4, out_tag4, ref4(2'b01, d));
        end
        cycle4();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_forward_nb4();
        test_inverse_bypass_nb4();
        test_nb8();
        test_backpressure();
        test_streaming();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_rows_stream.md
Name: shift_rows_stream

Overview:
Parametrised, stream-handshaked row-shift stage for the AES/Rijndael datapath. It supports forward ShiftRows, inverse InvShiftRows and bypass, selectable per beat. It handles Rijndael block widths of 4, 6 or 8 columns. It sits between SubBytes and MixColumns, and between their inverses, in the round pipeline, and absorbs downstream backpressure with a 2-entry skid buffer.

Parameters:
NB, 4, state columns (legal: 4, 6, 8; any other value is an elaboration error); block width = 32*NB bits
TAG_W, 4, width of the sideband tag carried alongside each beat (≥1)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input beat valid
in_ready  out  1  stage can accept a beat
in_mode  in  2  00 forward, 01 inverse, 10 bypass, 11 treated as bypass
in_tag  in  TAG_W  sideband, passed through unchanged
in_data  in  32*NB  state; byte (r,c) at bits [(4c+r)*8 +: 8]
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts
out_tag  out  TAG_W  tag of the output beat
out_data  out  32*NB  permuted state

Behaviour:
- Shift offsets s(r) for rows 0..3: NB=4 or 6 → 0,1,2,3; NB=8 → 0,1,3,4.
- Forward: out(r,c) = in(r,(c+s(r)) mod NB).
- Inverse: out(r,c) = in(r,(c−s(r)) mod NB).
- Bypass: out = in.
- Permutation is applied combinationally to in_data before capture. Mode and tag are sampled with the data on the accepting edge.
- Storage is an output register (O) plus a skid register (S), each with its own valid bit.
- A transfer occurs on the rising edge where in_valid && in_ready (accept) or out_valid && out_ready (drain).
- in_ready = !S.valid. It is driven from a register, with no combinational path from out_ready.
- out_valid = O.valid; out_data and out_tag always reflect the O contents.
- Edge rules:
  - Accept while O is empty, or O is draining this cycle with S empty → permuted beat loads O.
  - Accept while O is valid and not draining → beat loads S.
  - Drain with S valid → S moves to O and S is cleared. in_ready cannot be high in this case.
  - Drain with no accept and S empty → O.valid clears.
- Latency is 1 cycle from accept to out_valid when the stage is empty. Throughput is 1 beat/cycle while out_ready is held high.
- Ordering is strictly FIFO and no beat is ever dropped or duplicated.
- Full condition: O and S both valid → in_ready=0. It reasserts on the edge after the first drain.
- Data and tag registers hold their value while the stage is stalled (out_valid && !out_ready).
- Reset, asynchronous on rst_n low, whether idle or mid-stream:
  - O.valid=0, S.valid=0, in_ready=1 from the first edge after rst_n rises (held 0 during reset), out_valid=0, out_data=0, out_tag=0.
  - All in-flight beats are discarded.
- No arithmetic is involved; the block is pure byte routing.

Decomposition:
- Shared package aes_pkg holds:
  - the mode encoding constants (MODE_FWD=2'b00, MODE_INV=2'b01, MODE_BYP=2'b10);
  - a constant function row_shift(nb, r) returning s(r);
  - a byte-index helper for (r,c) to bit offset.
- Sub-module rijndael_row_permute (parameter NB; ports: mode, data_in, data_out) contains the combinational permutation only.
- shift_rows_stream owns the handshake, the skid logic and the registers.

Test Plan:
- NB=4 forward: send bytes 0..15 as d4 27 11 ae e0 bf 98 f1 b8 b4 5d e5 1e 41 52 30 (byte0 at [7:0]) with tag 3 and out_ready=1 → next cycle out_valid=1, bytes d4 bf 5d 30 e0 b4 52 ae b8 41 11 f1 1e 27 98 e5, tag 3.
- NB=4 inverse: send the forward output above with mode 01 → the original d4 27 11 ae… sequence. Bypass mode returns the input unchanged.
- NB=8 forward with input byte k = k (k=0..31) → output bytes 0..3 = 00 05 0e 13. A following inverse beat restores the identity, and the check covers all 32 bytes.
- Backpressure: hold out_ready=0 and offer 3 consecutive beats A, B, C → A and B accepted, in_ready=0 while C is held. Raise out_ready → A, B, C emerge in order with no gaps once flowing, and in_ready=1 one cycle after the first drain.
- Streaming: offer 20 back-to-back beats while toggling out_ready randomly → output order and tags match input, and the beat count is 20.
- Reset mid-stream: with O and S full, pulse rst_n low asynchronously between clock edges → out_valid=0 and out_data=0 immediately. After release in_ready=1, no stale beat appears, and the next beat has latency 1.
